// File: rtl/universal_shift_reg_ctrl.sv
// ---------------------------------------------------------------------------
// universal_shift_reg_ctrl
//   N-bit shift register with a multi-cycle shift controller. A parallel load
//   or a start request is accepted in IDLE. A start shifts the register by the
//   captured amount, one bit per clock, in one of four modes.
//
//   Optional feature macro: SHIFT_ABORT_EN (adds the abort input).
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   asynchronous, active-high reset
//   load_en     in   parallel load request (IDLE only, wins over start)
//   data_in     in   [N-1:0] parallel load data
//   start       in   shift request (IDLE only)
//   mode        in   [1:0] 00 lsr, 01 lsl, 10 ror, 11 asr (captured on start)
//   amount      in   [CNT_W-1:0] number of 1-bit shifts (captured on start)
//   serial_in   in   fill bit for lsr/lsl, sampled every shift cycle
//   data_out    out  [N-1:0] register contents
//   serial_out  out  bit shifted out by the most recent shift
//   busy        out  high while in SHIFT
//   done        out  one-cycle completion pulse
//   abort       in   (SHIFT_ABORT_EN only) cancel a running shift
//
// Request semantics: load_en and start are single-cycle level requests that
// are accepted only on an edge where state is IDLE; in SHIFT and DONE they are
// ignored and not remembered. busy is the "not ready" indication. The internal
// enum signal `state` is the observable FSM state for checkers.
// ---------------------------------------------------------------------------
module universal_shift_reg_ctrl #(
  parameter int N     = 14,
  parameter int CNT_W = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_en,
  input  logic [N-1:0]     data_in,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] amount,
  input  logic             serial_in,
`ifdef SHIFT_ABORT_EN
  input  logic             abort,
`endif
  output logic [N-1:0]     data_out,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] M_LSR = 2'b00;
  localparam logic [1:0] M_LSL = 2'b01;
  localparam logic [1:0] M_ROR = 2'b10;
  localparam logic [1:0] M_ASR = 2'b11;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       mode_q;
  logic [N-1:0]     reg_q;
  logic             sout_q;
  logic             abort_req;

`ifdef SHIFT_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (!load_en && start) begin
          // A zero-length operation still reports completion.
          state_next = (amount != '0) ? S_SHIFT : S_DONE;
        end
      end
      S_SHIFT: begin
        if (abort_req) begin
          state_next = S_IDLE;
        end else if (cnt == CNT_W'(1)) begin
          state_next = S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // FSM: outputs decoded from registered state only
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_SHIFT: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: register, serial output, counter and captured mode
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_q  <= '0;
      sout_q <= 1'b0;
      cnt    <= '0;
      mode_q <= M_LSR;
    end else begin
      case (state)
        S_IDLE: begin
          if (load_en) begin
            reg_q  <= data_in;
            sout_q <= 1'b0;
          end else if (start) begin
            mode_q <= mode;
            cnt    <= amount;
          end
        end
        S_SHIFT: begin
          if (abort_req) begin
            // Keep the partially shifted value; no shift on this edge.
            cnt <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
            case (mode_q)
              M_LSR: begin
                reg_q  <= {serial_in, reg_q[N-1:1]};
                sout_q <= reg_q[0];
              end
              M_LSL: begin
                reg_q  <= {reg_q[N-2:0], serial_in};
                sout_q <= reg_q[N-1];
              end
              M_ROR: begin
                reg_q  <= {reg_q[0], reg_q[N-1:1]};
                sout_q <= reg_q[0];
              end
              default: begin // M_ASR
                reg_q  <= {reg_q[N-1], reg_q[N-1:1]};
                sout_q <= reg_q[0];
              end
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  assign data_out   = reg_q;
  assign serial_out = sout_q;

endmodule

// File: tb/tb_universal_shift_reg_ctrl.sv
// ---------------------------------------------------------------------------
// tb_universal_shift_reg_ctrl
//   Directed, table-driven bench for universal_shift_reg_ctrl (N=14).
//   Inputs are driven on the falling edge; outputs are sampled on the falling
//   edge, half a cycle away from the active rising edge.
// ---------------------------------------------------------------------------
module tb_universal_shift_reg_ctrl;

  localparam int N     = 14;
  localparam int CNT_W = $clog2(N + 1);

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             reset;
  logic             load_en;
  logic [N-1:0]     data_in;
  logic             start;
  logic [1:0]       mode;
  logic [CNT_W-1:0] amount;
  logic             serial_in;
  logic             abort;
  logic [N-1:0]     data_out;
  logic             serial_out;
  logic             busy;
  logic             done;

  always #5 clk = ~clk;

  universal_shift_reg_ctrl #(.N(N), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_en    (load_en),
    .data_in    (data_in),
    .start      (start),
    .mode       (mode),
    .amount     (amount),
    .serial_in  (serial_in),
`ifdef SHIFT_ABORT_EN
    .abort      (abort),
`endif
    .data_out   (data_out),
    .serial_out (serial_out),
    .busy       (busy),
    .done       (done)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act);
    logic [31:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: got 0x%0h, no expected value queued", name, act);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        errors++;
        $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
    end
  endtask

  task automatic expect_val(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    load_en   = 1'b0;
    data_in   = '0;
    start     = 1'b0;
    mode      = 2'b00;
    amount    = '0;
    serial_in = 1'b0;
    abort     = 1'b0;
  endtask

  task automatic do_load(input logic [N-1:0] v);
    @(negedge clk);
    load_en = 1'b1;
    data_in = v;
    @(negedge clk);
    load_en = 1'b0;
    data_in = '0;
  endtask

  // Starts an operation and waits (bounded) for done. Mode/amount are
  // scrambled and load_en is held high after capture to show they are
  // ignored during SHIFT and DONE.
  task automatic run_op(input logic [1:0] m, input logic [CNT_W-1:0] a,
                        input logic si,
                        output int busy_cycles, output bit done_seen,
                        output logic [N-1:0] d_final, output logic s_final,
                        output logic done_after, output logic busy_after);
    @(negedge clk);
    start     = 1'b1;
    mode      = m;
    amount    = a;
    serial_in = si;
    @(negedge clk);
    start   = 1'b0;
    mode    = ~m;
    amount  = ~a;
    load_en = 1'b1;
    data_in = 14'h3C3C;
    busy_cycles = 0;
    done_seen   = 1'b0;
    d_final     = '0;
    s_final     = 1'b0;
    for (int i = 0; i < 64 && !done_seen; i++) begin
      if (done) begin
        done_seen = 1'b1;
        d_final   = data_out;
        s_final   = serial_out;
        load_en   = 1'b0;
        data_in   = '0;
      end else begin
        if (busy) busy_cycles++;
        @(negedge clk);
      end
    end
    load_en = 1'b0;
    @(negedge clk);
    done_after = done;
    busy_after = busy;
    mode   = 2'b00;
    amount = '0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [N-1:0]     load_val;
    logic [1:0]       mode;
    logic [CNT_W-1:0] amt;
    logic             si;
    logic [N-1:0]     exp_data;
    logic             exp_sout;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int           bc;
    bit           ds;
    logic [N-1:0] df;
    logic         sf;
    logic         da;
    logic         ba;

    //          load      mode   amt  si  exp_data  exp_sout
    vecs[0]  = '{14'h2AB5, 2'b00, 4'd3,  1'b0, 14'h0556, 1'b1}; // lsr 3
    vecs[1]  = '{14'h2AB5, 2'b01, 4'd2,  1'b1, 14'h2AD7, 1'b0}; // lsl 2, fill 1
    vecs[2]  = '{14'h2001, 2'b11, 4'd4,  1'b0, 14'h3E00, 1'b0}; // asr 4
    vecs[3]  = '{14'h0001, 2'b10, 4'd1,  1'b0, 14'h2000, 1'b1}; // ror 1
    vecs[4]  = '{14'h1234, 2'b00, 4'd0,  1'b1, 14'h1234, 1'b0}; // amount 0
    vecs[5]  = '{14'h2AB5, 2'b10, 4'd14, 1'b0, 14'h2AB5, 1'b1}; // ror by N
    vecs[6]  = '{14'h0000, 2'b00, 4'd15, 1'b1, 14'h3FFF, 1'b1}; // lsr saturate
    vecs[7]  = '{14'h2000, 2'b11, 4'd15, 1'b0, 14'h3FFF, 1'b1}; // asr saturate
    vecs[8]  = '{14'h0013, 2'b10, 4'd5,  1'b0, 14'h2600, 1'b1}; // ror 5
    vecs[9]  = '{14'h2000, 2'b01, 4'd1,  1'b1, 14'h0001, 1'b1}; // lsl 1, fill 1
    vecs[10] = '{14'h0002, 2'b00, 4'd1,  1'b1, 14'h2001, 1'b0}; // lsr 1, fill 1

    idle_inputs();
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    expect_val(0); check("rst_data_out",   32'(data_out));
    expect_val(0); check("rst_serial_out", 32'(serial_out));
    expect_val(0); check("rst_busy",       32'(busy));
    expect_val(0); check("rst_done",       32'(done));
    reset = 1'b0;

    // Async reset mid-cycle after a load
    do_load(14'h2AB5);
    expect_val(32'h2AB5); check("load_data", 32'(data_out));
    #2 reset = 1'b1;
    #1;
    expect_val(0); check("async_rst_data", 32'(data_out));
    expect_val(0); check("async_rst_sout", 32'(serial_out));
    expect_val(0); check("async_rst_busy", 32'(busy));
    expect_val(0); check("async_rst_done", 32'(done));
    @(negedge clk);
    reset = 1'b0;

    // Table-driven operations
    for (int i = 0; i < 11; i++) begin
      do_load(vecs[i].load_val);
      run_op(vecs[i].mode, vecs[i].amt, vecs[i].si, bc, ds, df, sf, da, ba);
      expect_val(1);               check($sformatf("v%0d_done_seen", i), 32'(ds));
      expect_val(vecs[i].amt);     check($sformatf("v%0d_busy_cycles", i), 32'(bc));
      expect_val(vecs[i].exp_data); check($sformatf("v%0d_data", i), 32'(df));
      expect_val(vecs[i].exp_sout); check($sformatf("v%0d_sout", i), 32'(sf));
      expect_val(0);               check($sformatf("v%0d_done_1cyc", i), 32'(da));
      expect_val(0);               check($sformatf("v%0d_idle_after", i), 32'(ba));
      expect_val(vecs[i].exp_data); check($sformatf("v%0d_no_late_load", i), 32'(data_out));
    end

    // load_en and start together: load wins, no busy, no done
    @(negedge clk);
    load_en = 1'b1; data_in = 14'h1111; start = 1'b1; mode = 2'b00; amount = 4'd3;
    @(negedge clk);
    load_en = 1'b0; start = 1'b0; amount = '0;
    expect_val(32'h1111); check("ld_st_data", 32'(data_out));
    expect_val(0);        check("ld_st_busy", 32'(busy));
    expect_val(0);        check("ld_st_done", 32'(done));
    @(negedge clk);
    expect_val(0);        check("ld_st_busy2", 32'(busy));
    expect_val(0);        check("ld_st_done2", 32'(done));
    expect_val(32'h1111); check("ld_st_data2", 32'(data_out));

    // Back-to-back: start held high; ignored in DONE, accepted in next IDLE
    do_load(14'h0001);
    @(negedge clk);
    start = 1'b1; mode = 2'b10; amount = 4'd1;
    @(negedge clk);                       // after edge 0
    expect_val(1); check("b2b_busy_e0", 32'(busy));
    @(negedge clk);                       // after edge 1
    expect_val(1); check("b2b_done_e1", 32'(done));
    expect_val(32'h2000); check("b2b_data_e1", 32'(data_out));
    @(negedge clk);                       // after edge 2 (DONE -> IDLE)
    expect_val(0); check("b2b_busy_e2", 32'(busy));
    expect_val(0); check("b2b_done_e2", 32'(done));
    @(negedge clk);                       // after edge 3 (accepted)
    start = 1'b0; amount = '0; mode = 2'b00;
    expect_val(1); check("b2b_busy_e3", 32'(busy));
    @(negedge clk);                       // after edge 4
    expect_val(1); check("b2b_done_e4", 32'(done));
    expect_val(32'h1000); check("b2b_data_e4", 32'(data_out));

    // Reset in the middle of a long lsr
    do_load(14'h2AB5);
    @(negedge clk);
    start = 1'b1; mode = 2'b00; amount = 4'd10; serial_in = 1'b0;
    @(negedge clk);
    start = 1'b0; amount = '0;
    repeat (4) @(posedge clk);
    #1;
    expect_val(1); check("mid_busy_e4", 32'(busy));
    expect_val(32'h02AB); check("mid_data_e4", 32'(data_out));
    reset = 1'b1;
    #1;
    expect_val(0); check("mid_rst_data", 32'(data_out));
    expect_val(0); check("mid_rst_sout", 32'(serial_out));
    expect_val(0); check("mid_rst_busy", 32'(busy));
    expect_val(0); check("mid_rst_done", 32'(done));
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    expect_val(0); check("mid_rst_idle_busy", 32'(busy));
    expect_val(0); check("mid_rst_idle_done", 32'(done));

`ifdef SHIFT_ABORT_EN
    // Abort sampled at edge 4: IDLE, partial value kept, no done
    do_load(14'h2AB5);
    @(negedge clk);
    start = 1'b1; mode = 2'b00; amount = 4'd10; serial_in = 1'b0;
    @(negedge clk);                       // after edge 0
    start = 1'b0; amount = '0;
    repeat (3) @(negedge clk);            // after edge 3
    abort = 1'b1;
    @(negedge clk);                       // after edge 4
    abort = 1'b0;
    expect_val(0); check("abort_busy", 32'(busy));
    expect_val(0); check("abort_done", 32'(done));
    expect_val(32'h0556); check("abort_data", 32'(data_out));
    @(negedge clk);
    expect_val(0); check("abort_no_done", 32'(done));
    expect_val(32'h0556); check("abort_data_hold", 32'(data_out));
`endif

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
